if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It sits directly upstream of the ID-stage branch comparator and consumes that comparator's `takebranch` decision, redirecting the PC and squashing the wrong-path instruction. It talks to instruction memory through a req/ready handshake, holds IF/ID under hazard stalls using a one-entry skid buffer, and tracks redirects that land while a fetch is still outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clock` in 1: core clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: ID-stage hold from the hazard unit; IF/ID must not change while high.
- `takebranch` in 1: branch taken, resolved in ID.
- `branch_target` in 32: redirect address, valid when `takebranch`=1.
- `imem_addr` out 32: fetch address; held stable while `imem_req`=1 until `imem_ready`.
- `imem_req` out 1: fetch request.
- `imem_rdata` in 32: instruction, valid in the cycle `imem_ready`=1.
- `imem_ready` in 1: memory response.
- `ifid_ir` out 32: instruction to ID.
- `ifid_pc4` out 32: PC+4 of `ifid_ir`.
- `ifid_valid` out 1: IF/ID holds a live instruction.

## Operation
- State: `pc` (32), skid buffer `skid_ir`/`skid_pc4`, `redir_pc` (32), FSM {FETCH, HOLD, DRAIN}.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - Ready and not stall: IF/ID loads {rdata, pc+4}; `ifid_valid`=1; `pc`+=4.
  - Ready and stall: capture into skid; `pc`+=4; go to HOLD.
  - Not ready and not stall: `ifid_valid`=0 (bubble).
  - Not ready and stall: IF/ID holds.
- HOLD: `imem_req`=0. On stall=0, IF/ID loads from skid, `ifid_valid`=1, then FETCH.
- DRAIN: `imem_req`=1, addr held. On ready, discard data; `pc`=`redir_pc`; go to FETCH.
- `takebranch` is honoured only when `stall`=0; while `stall`=1 it is ignored.
- Honoured `takebranch` has the highest priority:
  - `ifid_valid`=0 (flush the wrong-path slot).
  - Skid is discarded.
  - If in FETCH with `imem_ready`=0, latch `redir_pc`=`branch_target` and go to DRAIN.
  - Otherwise set `pc`=`branch_target` and go to FETCH; any data returned in that cycle is dropped.
- `takebranch` during DRAIN overwrites `redir_pc`; the last target wins.
- PC arithmetic is mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `branch_target` low bits are passed unchanged; alignment is not checked.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=FETCH.
  - `ifid_ir`=0, `ifid_pc4`=0, `ifid_valid`=0.
  - `imem_req` is 1 in the first cycle after deassertion.
- Zero-wait memory: one instruction per cycle; latency is 1 cycle from `imem_ready` to `ifid_valid`.
- Taken branch with ready memory: exactly one bubble, and the target is fetched in the next cycle.
- Redirect with fetch outstanding: target fetch starts the cycle after the drain's `imem_ready`.
- Reset mid-fetch or mid-drain: immediate return to reset values; the pending redirect is lost.

## Configuration
- `IF_FETCH_PERF_EN` defined:
  - Adds output ports `perf_fetched` [31:0] (instructions loaded into IF/ID with valid=1) and `perf_flushed` [31:0] (honoured `takebranch` events).
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters are absent; functional behaviour is identical.

## Test plan
- Reset with `RESET_PC`=32'h400, zero-wait memory returning word=addr: IF/ID shows (0x400,0x404), (0x404,0x408), … in consecutive cycles, starting the cycle after the first ready.
- Stall high for 3 cycles while ready=1: IF/ID is frozen; `imem_req`=0 after one capture; on release the skid instruction appears, then normal flow with no instruction lost or duplicated.
- `takebranch`=1, target=0x1000, ready=1: next cycle `ifid_valid`=0 and `imem_addr`=0x1000; the following cycle IF/ID holds 0x1000's instruction with pc4=0x1004.
- `takebranch` to 0x2000 while ready held low for 4 cycles: `imem_addr` stays at the old PC until ready; the returned word is never seen in ID; the next request is 0x2000.
- `takebranch`=1 together with `stall`=1: no redirect and no flush; IF/ID unchanged.
- `reset_n` pulsed low asynchronously during DRAIN: outputs go to reset values immediately; fetch resumes at `RESET_PC`. With `IF_FETCH_PERF_EN`, counters read 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch and IF/ID pipeline register for the 5-stage MIPS core.
// Fetches via a req/ready handshake, holds IF/ID under stall with a one-entry skid buffer,
// and redirects on the ID-stage taken-branch decision. A redirect that lands while a fetch
// is still outstanding is parked until the old response drains.
// Optional build macro IF_FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        takebranch,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] ifid_ir_q, ifid_ir_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc_plus4;
  logic        honour;

  // A branch decision is only meaningful when ID is not held by the hazard unit.
  assign honour   = takebranch && !stall;
  assign pc_plus4 = pc_q + 32'd4;

  // State register: FSM plus PC, redirect, skid and IF/ID datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      redir_q      <= 32'h0;
      skid_ir_q    <= 32'h0;
      skid_pc4_q   <= 32'h0;
      ifid_ir_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_q      <= redir_d;
      skid_ir_q    <= skid_ir_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Next-state logic; a honoured branch overrides every other transition.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    skid_ir_d    = skid_ir_q;
    skid_pc4_d   = skid_pc4_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (honour) begin
      // Skid contents become dead simply by leaving StHold.
      ifid_valid_d = 1'b0;
      if (state_q != StHold && !imem_ready) begin
        redir_d = branch_target;
        state_d = StDrain;
      end else begin
        pc_d    = branch_target;
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_ir_d  = imem_rdata;
              skid_pc4_d = pc_plus4;
              state_d    = StHold;
            end else begin
              ifid_ir_d    = imem_rdata;
              ifid_pc4_d   = pc_plus4;
              ifid_valid_d = 1'b1;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!stall) begin
            ifid_ir_d    = skid_ir_q;
            ifid_pc4_d   = skid_pc4_q;
            ifid_valid_d = 1'b1;
            state_d      = StFetch;
          end
        end
        StDrain: begin
          // Response to the abandoned fetch is dropped on the floor.
          if (imem_ready) begin
            pc_d    = redir_q;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // Output logic: request whenever not parked on a full skid buffer.
  always_comb begin
    imem_req   = (state_q != StHold);
    imem_addr  = pc_q;
    ifid_ir    = ifid_ir_q;
    ifid_pc4   = ifid_pc4_q;
    ifid_valid = ifid_valid_q;
  end

`ifdef IF_FETCH_PERF_EN
  logic fetch_inc;

  // Counts instructions entering IF/ID as live: direct from memory or out of the skid.
  assign fetch_inc = !honour && !stall &&
                     ((state_q == StFetch && imem_ready) || state_q == StHold);

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= 32'h0;
      perf_flushed <= 32'h0;
    end else begin
      if (fetch_inc) perf_fetched <= perf_fetched + 32'd1;
      if (honour)    perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed plus randomized bench for if_fetch_stage with a
// transaction-level reference model (PC, skid queue, pending redirect).
module tb_if_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0400;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        takebranch;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  if_fetch_stage #(
    .RESET_PC(RPC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .takebranch   (takebranch),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .ifid_ir      (ifid_ir),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  logic [31:0] m_ir;
  logic [31:0] m_pc4;
  bit          m_pend;
  bit          m_valid;
  logic [63:0] m_skid[$];
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RPC;
    m_redir   = 32'h0;
    m_ir      = 32'h0;
    m_pc4     = 32'h0;
    m_pend    = 1'b0;
    m_valid   = 1'b0;
    m_skid.delete();
    m_fetched = 32'h0;
    m_flushed = 32'h0;
  endtask

  task automatic check_outputs(input string tag);
    bit exp_req;
    exp_req = (m_skid.size() == 0);
    check({tag, ".req"}, {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) check({tag, ".addr"}, imem_addr, m_pc);
    check({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
    if (m_valid) begin
      check({tag, ".ir"}, ifid_ir, m_ir);
      check({tag, ".pc4"}, ifid_pc4, m_pc4);
    end
`ifdef IF_FETCH_PERF_EN
    check({tag, ".fetched"}, perf_fetched, m_fetched);
    check({tag, ".flushed"}, perf_flushed, m_flushed);
`endif
  endtask

  // One clock of behaviour, expressed in terms of queue occupancy and a pending redirect.
  task automatic model_update(input bit s, input bit tb, input logic [31:0] tgt,
                              input bit rdy, input logic [31:0] rd);
    bit req;
    req = (m_skid.size() == 0);
    if (tb && !s) begin
      m_valid = 1'b0;
      m_flushed++;
      m_skid.delete();
      if (req && !rdy) begin
        m_pend  = 1'b1;
        m_redir = tgt;
      end else begin
        m_pc   = tgt;
        m_pend = 1'b0;
      end
    end else if (m_skid.size() != 0) begin
      if (!s) begin
        {m_ir, m_pc4} = m_skid.pop_front();
        m_valid = 1'b1;
        m_fetched++;
      end
    end else if (m_pend) begin
      if (rdy) begin
        m_pc   = m_redir;
        m_pend = 1'b0;
      end
    end else if (rdy) begin
      if (s) m_skid.push_back({rd, m_pc + 32'd4});
      else begin
        m_ir    = rd;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_fetched++;
      end
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_valid = 1'b0;
    end
  endtask

  // Entered at a falling edge; drives, checks current state, advances model, ends one cycle on.
  task automatic step(input string tag, input bit s, input bit tb, input logic [31:0] tgt,
                      input bit rdy);
    logic [31:0] rd;
    rd            = m_pc;  // memory returns word == address
    stall         = s;
    takebranch    = tb;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_rdata    = rd;
    #1;
    check_outputs(tag);
    model_update(s, tb, tgt, rdy, rd);
    @(negedge clock);
  endtask

  initial begin
    reset_n       = 1'b0;
    stall         = 1'b0;
    takebranch    = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    model_reset();
    #12;
    check("rst.ir", ifid_ir, 32'h0);
    check("rst.pc4", ifid_pc4, 32'h0);
    check_outputs("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Zero-wait streaming.
    for (int i = 0; i < 5; i++) step("stream", 1'b0, 1'b0, 32'h0, 1'b1);
    // Stall for three cycles with memory ready, then release.
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step("unstall", 1'b0, 1'b0, 32'h0, 1'b1);
    // Taken branch with ready memory.
    step("br1000", 1'b0, 1'b1, 32'h0000_1000, 1'b1);
    for (int i = 0; i < 3; i++) step("br1000.post", 1'b0, 1'b0, 32'h0, 1'b1);
    // Taken branch while fetch outstanding for four cycles.
    step("br2000", 1'b0, 1'b1, 32'h0000_2000, 1'b0);
    for (int i = 0; i < 3; i++) step("drain", 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step("drain.post", 1'b0, 1'b0, 32'h0, 1'b1);
    // Branch during drain: last target wins.
    step("brA", 1'b0, 1'b1, 32'h0000_3000, 1'b0);
    step("brB", 1'b0, 1'b1, 32'h0000_4000, 1'b0);
    for (int i = 0; i < 3; i++) step("brB.post", 1'b0, 1'b0, 32'h0, 1'b1);
    // Branch together with stall is ignored.
    step("brstall", 1'b1, 1'b1, 32'h0000_5000, 1'b0);
    step("brstall2", 1'b1, 1'b1, 32'h0000_5000, 1'b0);
    for (int i = 0; i < 2; i++) step("brstall.post", 1'b0, 1'b0, 32'h0, 1'b1);
    // PC wrap and unaligned target.
    step("wrap", 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 4; i++) step("wrap.post", 1'b0, 1'b0, 32'h0, 1'b1);
    step("unal", 1'b0, 1'b1, 32'h0000_6002, 1'b1);
    for (int i = 0; i < 2; i++) step("unal.post", 1'b0, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset in the middle of a drain.
    step("pre_rst", 1'b0, 1'b1, 32'h0000_7000, 1'b0);
    step("in_drain", 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst.ir", ifid_ir, 32'h0);
    check("arst.pc4", ifid_pc4, 32'h0);
    check_outputs("arst");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step("after_rst", 1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit          s;
      bit          tb;
      bit          rdy;
      logic [31:0] tgt;
      s   = ($urandom_range(0, 3) == 0);
      tb  = ($urandom_range(0, 6) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      tgt = $urandom();
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      step("rand", s, tb, tgt, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
